// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate generator stage: immediate format enum,
// RISC-V major opcodes recognised by the auto-decoder, and the per-word
// decode metadata carried alongside the extended immediate.
package imm_gen_stage_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Resolved format plus illegal flag; the XLEN/TAG_W-dependent payload
  // wrapping this lives in the top where those widths are known.
  typedef struct packed {
    imm_type_e sel;
    logic      illegal;
  } imm_meta_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream/downstream valid-ready bus of the immediate generator stage.
//   in_*  : instruction word, manual format selector, sideband tag
//   out_* : extended immediate, resolved format, illegal flag, tag
// slave  = the stage's view, master = the environment driving it.
interface imm_gen_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_sel;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_sel, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_instr, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_sel, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_stage_format.sv
// Combinational immediate extractor.
//   instr  : 32-bit instruction word
//   sel_in : format when AUTO_DECODE=0 (0..5 = I,S,B,U,J,Z; 6,7 illegal)
//   imm    : immediate extended to XLEN (zero when illegal)
//   meta   : resolved format (I when illegal) and illegal flag
module imm_format
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel_in,
  output logic [XLEN-1:0] imm,
  output imm_meta_t       meta
);

  imm_type_e       ty;
  logic            illegal;
  logic            s;
  logic [XLEN-1:0] ext;

  assign s = instr[31];

  always_comb begin
    ty      = IMM_I;
    illegal = 1'b0;
    if (AUTO_DECODE) begin
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR: ty = IMM_I;
        OP_STORE:                 ty = IMM_S;
        OP_BRANCH:                ty = IMM_B;
        OP_LUI, OP_AUIPC:         ty = IMM_U;
        OP_JAL:                   ty = IMM_J;
        // funct3[2] separates the CSR-immediate forms from the register forms
        OP_SYSTEM:                ty = instr[14] ? IMM_Z : IMM_I;
        default:                  illegal = 1'b1;
      endcase
    end else if (sel_in <= 3'd5) begin
      ty = imm_type_e'(sel_in);
    end else begin
      illegal = 1'b1;
    end
  end

  always_comb begin
    ext = '0;
    case (ty)
      IMM_I: ext = {{(XLEN-11){s}}, instr[30:20]};
      IMM_S: ext = {{(XLEN-11){s}}, instr[30:25], instr[11:7]};
      IMM_B: ext = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: ext = {{(XLEN-31){s}}, instr[30:12], 12'b0};
      IMM_J: ext = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z: ext = {{(XLEN-5){1'b0}}, instr[19:15]};
      default: ext = '0;
    endcase
  end

  always_comb begin
    meta.illegal = illegal;
    meta.sel     = illegal ? IMM_I : ty;
    imm          = illegal ? '0 : ext;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: imm_format feeding an output register
// backed by a one-entry skid register (two words of storage total).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   flush    : drops all held words and any same-cycle accept
//   bus      : valid/ready in/out bus (see imm_gen_stage_if)
// in_ready is purely registered (!skid_valid_q), so there is no
// combinational path from out_ready to in_ready.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          AUTO_DECODE = 1'b1,
  parameter int unsigned TAG_W       = 5
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  imm_gen_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_meta_t        meta;
    logic [TAG_W-1:0] tag;
  } payload_t;

  logic [XLEN-1:0] fmt_imm;
  imm_meta_t       fmt_meta;
  payload_t        new_pl;
  payload_t        out_d, out_q, skid_d, skid_q;
  logic            out_valid_d, out_valid_q;
  logic            skid_valid_d, skid_valid_q;
  logic            accept, consume;

  imm_format #(
    .XLEN        (XLEN),
    .AUTO_DECODE (AUTO_DECODE)
  ) u_fmt (
    .instr  (bus.in_instr),
    .sel_in (bus.in_sel),
    .imm    (fmt_imm),
    .meta   (fmt_meta)
  );

  always_comb begin
    new_pl       = '{imm: fmt_imm, meta: fmt_meta, tag: bus.in_tag};
    accept       = bus.in_valid && !skid_valid_q;
    consume      = out_valid_q && bus.out_ready;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume || !out_valid_q) begin
      // Output slot frees up: the skid word is older, so it goes first.
      // A full skid implies in_ready=0, so no accept competes with it.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_pl;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_pl;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_sel     = out_q.meta.sel;
  assign bus.out_illegal = out_q.meta.illegal;
  assign bus.out_tag     = out_q.tag;

endmodule
